// File: rtl/seg_display_scan.sv
// Multiplexed 8-digit 7-segment back-end for the clock/stopwatch.
// Takes one input snapshot per scan frame and converts it to BCD with a sequential double-dabble.
module seg_display_scan #(
  parameter int DIGIT_DIV = 5,
  parameter int BLINK_DIV = 2500
) (
  input  logic       Clock_5K,
  input  logic       Reset,
  input  logic       Control,
  input  logic [3:0] Hours,
  input  logic [5:0] Mins,
  input  logic [5:0] Secs,
  input  logic [9:0] MSecs,
  input  logic       AM_PM,
  input  logic       Alarm,
  input  logic       SW_State,
  output logic [6:0] Seg,
  output logic       Dp,
  output logic [7:0] DigitSel,
  output logic       AmLed,
  output logic       PmLed,
  output logic       AlarmLed
);

  localparam int DW = (DIGIT_DIV > 2) ? $clog2(DIGIT_DIV) : 1;
  localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam int NF = 4;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LOAD} state_t;

  logic [DW-1:0]         r_dwell, w_dwell_next;
  logic [2:0]            r_idx, w_idx_next;
  logic                  r_started, w_started_next;
  logic                  w_dwell_wrap, w_frame_tick;

  logic [BW-1:0]         r_bcnt, w_bcnt_next;
  logic                  r_phase, w_phase_next;
  logic                  w_blink_wrap;

  state_t                r_state, w_state_next;
  logic [3:0]            r_bitcnt;
  logic [NF-1:0][9:0]    r_bin;
  logic [NF-1:0][11:0]   r_bcd, w_bcd_adj, w_bcd_shift;
  logic [NF-1:0][9:0]    w_capture;
  logic [9:0]            w_msecs_clamped;
  logic                  r_snap_ctrl, r_snap_ampm, r_snap_alarm, r_snap_sw;

  logic [7:0][3:0]       r_disp;
  logic                  r_d_ctrl, r_d_ampm, r_d_alarm, r_d_sw;

  logic [3:0]            w_digit;
  logic [6:0]            w_code, w_seg_next;
  logic                  w_blank, w_dark, w_dp_next;
  logic [7:0]            w_sel_next;
  logic                  w_unused_bcd;

  // ---------------- scan timing ----------------
  always_comb begin
    w_dwell_wrap   = (r_dwell == DW'(DIGIT_DIV - 1));
    w_dwell_next   = w_dwell_wrap ? '0 : r_dwell + DW'(1);
    w_idx_next     = w_dwell_wrap ? r_idx + 3'd1 : r_idx;
    w_started_next = r_started | w_dwell_wrap;
    w_frame_tick   = w_dwell_wrap && (r_idx == 3'd7);
  end

  always_ff @(posedge Clock_5K or posedge Reset) begin
    if (Reset) begin
      r_dwell   <= '0;
      r_idx     <= '0;
      r_started <= 1'b0;
    end else begin
      r_dwell   <= w_dwell_next;
      r_idx     <= w_idx_next;
      r_started <= w_started_next;
    end
  end

  // ---------------- blink ----------------
  always_comb begin
    w_blink_wrap = (r_bcnt == BW'(BLINK_DIV - 1));
    w_bcnt_next  = w_blink_wrap ? '0 : r_bcnt + BW'(1);
    w_phase_next = r_phase ^ w_blink_wrap;
  end

  always_ff @(posedge Clock_5K or posedge Reset) begin
    if (Reset) begin
      r_bcnt  <= '0;
      r_phase <= 1'b1;
    end else begin
      r_bcnt  <= w_bcnt_next;
      r_phase <= w_phase_next;
    end
  end

  // ---------------- conversion FSM ----------------
  always_ff @(posedge Clock_5K or posedge Reset) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_frame_tick) w_state_next = S_SHIFT;
      S_SHIFT: if (r_bitcnt == 4'd9) w_state_next = S_LOAD;
      S_LOAD:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_msecs_clamped = (MSecs > 10'd999) ? 10'd999 : MSecs;
  assign w_capture = {w_msecs_clamped, {4'd0, Secs}, {4'd0, Mins}, {6'd0, Hours}};

  // One double-dabble step per field: add-3 on nibbles >= 5, then shift in the next binary bit.
  generate
    for (genvar gi = 0; gi < NF; gi++) begin : g_field
      for (genvar gj = 0; gj < 3; gj++) begin : g_nib
        assign w_bcd_adj[gi][4*gj +: 4] = (r_bcd[gi][4*gj +: 4] >= 4'd5)
                                          ? r_bcd[gi][4*gj +: 4] + 4'd3
                                          : r_bcd[gi][4*gj +: 4];
      end
      assign w_bcd_shift[gi] = {w_bcd_adj[gi][10:0], r_bin[gi][9]};
    end
  endgenerate

  always_ff @(posedge Clock_5K or posedge Reset) begin
    if (Reset) begin
      r_bin        <= '0;
      r_bcd        <= '0;
      r_bitcnt     <= '0;
      r_snap_ctrl  <= 1'b0;
      r_snap_ampm  <= 1'b0;
      r_snap_alarm <= 1'b0;
      r_snap_sw    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_frame_tick) begin
            r_bin        <= w_capture;
            r_bcd        <= '0;
            r_bitcnt     <= '0;
            r_snap_ctrl  <= Control;
            r_snap_ampm  <= AM_PM;
            r_snap_alarm <= Alarm;
            r_snap_sw    <= SW_State;
          end
        end
        S_SHIFT: begin
          r_bcd    <= w_bcd_shift;
          r_bitcnt <= r_bitcnt + 4'd1;
          for (int i = 0; i < NF; i++) r_bin[i] <= {r_bin[i][8:0], 1'b0};
        end
        default: ;
      endcase
    end
  end

  // ---------------- display registers (updated atomically in LOAD) ----------------
  always_ff @(posedge Clock_5K or posedge Reset) begin
    if (Reset) begin
      r_disp    <= '0;
      r_d_ctrl  <= 1'b0;
      r_d_ampm  <= 1'b0;
      r_d_alarm <= 1'b0;
      r_d_sw    <= 1'b0;
    end else if (r_state == S_LOAD) begin
      r_disp[0] <= r_bcd[0][7:4];
      r_disp[1] <= r_bcd[0][3:0];
      r_disp[2] <= r_bcd[1][7:4];
      r_disp[3] <= r_bcd[1][3:0];
      r_disp[4] <= r_bcd[2][7:4];
      r_disp[5] <= r_bcd[2][3:0];
      r_disp[6] <= r_bcd[3][11:8];
      r_disp[7] <= r_bcd[3][7:4];
      r_d_ctrl  <= r_snap_ctrl;
      r_d_ampm  <= r_snap_ampm;
      r_d_alarm <= r_snap_alarm;
      r_d_sw    <= r_snap_sw;
    end
  end

  // Hundreds of the two-digit fields and the millisecond units are never shown.
  assign w_unused_bcd = &{1'b0, r_bcd[0][11:8], r_bcd[1][11:8], r_bcd[2][11:8], r_bcd[3][3:0]};

  // ---------------- output decode ----------------
  always_comb begin
    w_digit = r_disp[w_idx_next];
    case (w_digit)
      4'd0:    w_code = 7'h3F;
      4'd1:    w_code = 7'h06;
      4'd2:    w_code = 7'h5B;
      4'd3:    w_code = 7'h4F;
      4'd4:    w_code = 7'h66;
      4'd5:    w_code = 7'h6D;
      4'd6:    w_code = 7'h7D;
      4'd7:    w_code = 7'h07;
      4'd8:    w_code = 7'h7F;
      4'd9:    w_code = 7'h6F;
      default: w_code = 7'h00;
    endcase

    w_blank = r_d_ctrl && ((w_idx_next >= 3'd6) || (w_idx_next == 3'd0 && w_digit == 4'd0));
    w_dark  = r_d_alarm && !w_phase_next;

    if (r_d_ctrl) w_dp_next = ((w_idx_next == 3'd1) || (w_idx_next == 3'd3)) && w_phase_next;
    else          w_dp_next = (w_idx_next == 3'd5) && (r_d_sw || w_phase_next);

    w_seg_next = w_code;
    if (!w_started_next || w_dark || w_blank) w_seg_next = 7'h00;
    if (!w_started_next || w_dark)            w_dp_next  = 1'b0;

    w_sel_next = w_started_next ? (8'h80 >> w_idx_next) : 8'h00;
  end

  always_ff @(posedge Clock_5K or posedge Reset) begin
    if (Reset) begin
      Seg      <= '0;
      Dp       <= 1'b0;
      DigitSel <= '0;
      AmLed    <= 1'b0;
      PmLed    <= 1'b0;
      AlarmLed <= 1'b0;
    end else begin
      Seg      <= w_seg_next;
      Dp       <= w_dp_next;
      DigitSel <= w_sel_next;
      AmLed    <= r_d_ctrl & ~r_d_ampm;
      PmLed    <= r_d_ctrl & r_d_ampm;
      AlarmLed <= r_d_alarm & w_phase_next;
    end
  end

endmodule

// File: tb/tb_seg_display_scan.sv
// Bench for seg_display_scan: directed digit tables, long Dp/alarm runs, random frames
// against a time-based reference model, and an asynchronous reset during conversion.
module tb_seg_display_scan;

  localparam int D  = 5;
  localparam int B  = 2500;
  localparam int FR = 8 * D;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ctrl = 1'b0;
  logic [3:0] hours = '0;
  logic [5:0] mins = '0;
  logic [5:0] secs = '0;
  logic [9:0] msecs = '0;
  logic       ampm = 1'b0;
  logic       alarm = 1'b0;
  logic       sw = 1'b0;
  logic [6:0] seg;
  logic       dp;
  logic [7:0] sel;
  logic       am_led, pm_led, al_led;

  always #5 clk = ~clk;

  seg_display_scan #(.DIGIT_DIV(D), .BLINK_DIV(B)) dut (
    .Clock_5K(clk), .Reset(rst), .Control(ctrl), .Hours(hours), .Mins(mins),
    .Secs(secs), .MSecs(msecs), .AM_PM(ampm), .Alarm(alarm), .SW_State(sw),
    .Seg(seg), .Dp(dp), .DigitSel(sel), .AmLed(am_led), .PmLed(pm_led), .AlarmLed(al_led)
  );

  typedef struct packed {
    logic       ctrl;
    logic [3:0] h;
    logic [5:0] m;
    logic [5:0] s;
    logic [9:0] ms;
    logic       ampm;
    logic       alarm;
    logic       sw;
  } snap_t;

  typedef struct {
    logic       ctrl;
    int         h, m, s, ms;
    logic       ampm, sw;
    logic [7:0][6:0] segs;
    logic       am, pm;
  } vec_t;

  snap_t cur, pend;
  bit    have_pend;
  int    pend_rdy;
  int    t;
  int    checks = 0;
  int    errors = 0;
  vec_t  tbl[5];

  function automatic logic [6:0] code(input int d);
    case (d)
      0: return 7'h3F; 1: return 7'h06; 2: return 7'h5B; 3: return 7'h4F; 4: return 7'h66;
      5: return 7'h6D; 6: return 7'h7D; 7: return 7'h07; 8: return 7'h7F; 9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [55:0] segs8(input logic [6:0] a, b, c, d, e, f, g, h);
    return {h, g, f, e, d, c, b, a};
  endfunction

  // Expected outputs after clock edge t, from the frame schedule and decimal arithmetic.
  task automatic check_model();
    int dg[8];
    int idx, ms;
    bit started, ph;
    logic [6:0] eseg;
    logic       edp, eam, epm, eal;
    logic [7:0] esel;
    idx     = (t / D) % 8;
    started = (t >= D);
    ph      = ((t / B) % 2) == 0;
    ms      = (int'(cur.ms) > 999) ? 999 : int'(cur.ms);
    dg[0] = int'(cur.h) / 10;  dg[1] = int'(cur.h) % 10;
    dg[2] = int'(cur.m) / 10;  dg[3] = int'(cur.m) % 10;
    dg[4] = int'(cur.s) / 10;  dg[5] = int'(cur.s) % 10;
    dg[6] = ms / 100;          dg[7] = (ms / 10) % 10;
    eseg = code(dg[idx]);
    if (cur.ctrl && (idx >= 6 || (idx == 0 && dg[0] == 0))) eseg = 7'h00;
    edp = cur.ctrl ? ((idx == 1 || idx == 3) && ph) : (idx == 5 && (cur.sw || ph));
    if (!started || (cur.alarm && !ph)) begin
      eseg = 7'h00;
      edp  = 1'b0;
    end
    esel = started ? (8'h80 >> idx) : 8'h00;
    eam  = cur.ctrl & ~cur.ampm;
    epm  = cur.ctrl & cur.ampm;
    eal  = cur.alarm & ph;
    checks++;
    if (seg !== eseg || dp !== edp || sel !== esel || am_led !== eam || pm_led !== epm || al_led !== eal) begin
      errors++;
      $display("FAIL model t=%0d seg=%h exp %h dp=%b exp %b sel=%h exp %h leds=%b%b%b exp %b%b%b",
               t, seg, eseg, dp, edp, sel, esel, am_led, pm_led, al_led, eam, epm, eal);
    end
  endtask

  task automatic step();
    @(posedge clk);
    t++;
    if (t % FR == 0) begin
      pend      = '{ctrl, hours, mins, secs, msecs, ampm, alarm, sw};
      pend_rdy  = t + 12;
      have_pend = 1'b1;
    end
    if (have_pend && t >= pend_rdy) begin
      cur       = pend;
      have_pend = 1'b0;
    end
    #1;
    check_model();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0d got %0h expected %0h", name, t, act, exp);
    end
  endtask

  task automatic model_reset();
    t         = 0;
    cur       = '0;
    have_pend = 1'b0;
  endtask

  initial begin
    int n_sel0, n_sel5, n_dp5, dp_bad, toggles, lit_dark;
    logic prev_al;

    tbl[0] = '{1'b1, 10, 45, 7, 0, 1'b1, 1'b0,
               segs8(7'h06, 7'h3F, 7'h66, 7'h6D, 7'h3F, 7'h07, 7'h00, 7'h00), 1'b0, 1'b1};
    tbl[1] = '{1'b1, 9, 0, 0, 0, 1'b0, 1'b0,
               segs8(7'h00, 7'h6F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h00, 7'h00), 1'b1, 1'b0};
    tbl[2] = '{1'b0, 0, 3, 59, 876, 1'b0, 1'b1,
               segs8(7'h3F, 7'h3F, 7'h3F, 7'h4F, 7'h6D, 7'h6F, 7'h7F, 7'h07), 1'b0, 1'b0};
    tbl[3] = '{1'b0, 12, 34, 56, 1023, 1'b1, 1'b0,
               segs8(7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h6F, 7'h6F), 1'b0, 1'b0};
    tbl[4] = '{1'b1, 0, 59, 30, 0, 1'b0, 1'b0,
               segs8(7'h00, 7'h3F, 7'h6D, 7'h6F, 7'h4F, 7'h3F, 7'h00, 7'h00), 1'b1, 1'b0};

    // Power-up reset
    #2 rst = 1'b1;
    #1;
    chk("reset_outputs", {20'd0, seg, dp, sel, am_led, pm_led, al_led}, 32'd0);
    @(posedge clk); @(posedge clk);
    @(negedge clk) rst = 1'b0;
    model_reset();

    // Directed table
    for (int v = 0; v < 5; v++) begin
      ctrl = tbl[v].ctrl; hours = 4'(tbl[v].h); mins = 6'(tbl[v].m); secs = 6'(tbl[v].s);
      msecs = 10'(tbl[v].ms); ampm = tbl[v].ampm; sw = tbl[v].sw; alarm = 1'b0;
      $display("vec %0d ctrl=%0d h=%0d m=%0d s=%0d ms=%0d", v, ctrl, hours, mins, secs, msecs);
      for (int c = 0; c < 2 * FR; c++) step();
      for (int c = 0; c < FR; c++) begin
        step();
        if (t % D == 0) begin
          chk($sformatf("vec%0d_digit%0d", v, (t / D) % 8), {25'd0, seg}, {25'd0, tbl[v].segs[(t / D) % 8]});
          if ((t / D) % 8 == 0) chk($sformatf("vec%0d_ampm_leds", v), {30'd0, am_led, pm_led}, {30'd0, tbl[v].am, tbl[v].pm});
        end
      end
    end

    // Stopwatch running: Dp steady on digit 5 only
    ctrl = 1'b0; hours = 0; mins = 3; secs = 59; msecs = 876; sw = 1'b1; alarm = 1'b0;
    for (int c = 0; c < 2 * FR; c++) step();
    n_sel5 = 0; n_dp5 = 0; dp_bad = 0;
    for (int c = 0; c < 6000; c++) begin
      step();
      if (sel == 8'h04) begin
        n_sel5++;
        if (dp) n_dp5++;
      end else if (dp) dp_bad++;
    end
    $display("stopwatch dp run: digit5 cycles=%0d lit=%0d stray=%0d", n_sel5, n_dp5, dp_bad);
    chk("sw_dp_stray", dp_bad, 0);
    chk("sw_dp_steady", n_dp5, (n_sel5 > 0) ? n_sel5 : -1);

    // Alarm blinking
    ctrl = 1'b1; hours = 10; mins = 45; secs = 7; ampm = 1'b1; alarm = 1'b1;
    for (int c = 0; c < 2 * FR; c++) step();
    n_sel0 = 0; toggles = 0; lit_dark = 0; prev_al = al_led;
    for (int c = 0; c < 6000; c++) begin
      step();
      if (sel == 8'h00) n_sel0++;
      if (al_led != prev_al) toggles++;
      if (!al_led && (seg != 7'h00 || dp)) lit_dark++;
      prev_al = al_led;
    end
    $display("alarm run: toggles=%0d idle_sel=%0d lit_in_dark=%0d", toggles, n_sel0, lit_dark);
    chk("alarm_scan_never_stops", n_sel0, 0);
    chk("alarm_led_toggles", (toggles >= 2) ? 1 : 0, 1);
    chk("alarm_dark_window", lit_dark, 0);

    // Random frames
    for (int f = 0; f < 60; f++) begin
      ctrl  = 1'($urandom_range(0, 1));
      hours = 4'($urandom_range(0, 15));
      mins  = 6'($urandom_range(0, 63));
      secs  = 6'($urandom_range(0, 63));
      msecs = 10'($urandom_range(0, 1023));
      ampm  = 1'($urandom_range(0, 1));
      sw    = 1'($urandom_range(0, 1));
      alarm = ($urandom_range(0, 5) == 0);
      $display("rand %0d ctrl=%0d h=%0d m=%0d s=%0d ms=%0d alarm=%0d", f, ctrl, hours, mins, secs, msecs, alarm);
      for (int c = 0, n = $urandom_range(20, 60); c < n; c++) step();
    end

    // Reset in the middle of a conversion
    alarm = 1'b0;
    for (int c = 0; c < FR && (t % FR) != 0; c++) step();
    for (int c = 0; c < 5; c++) step();
    #3 rst = 1'b1;
    #1;
    chk("midshift_reset_outputs", {20'd0, seg, dp, sel, am_led, pm_led, al_led}, 32'd0);
    @(posedge clk); @(posedge clk);
    @(negedge clk) rst = 1'b0;
    model_reset();
    ctrl = 1'b1; hours = 12; mins = 34; secs = 56; ampm = 1'b0; sw = 1'b0;
    $display("reset mid-shift released, new values h=12 m=34 s=56");
    for (int c = 0; c < 8 * D + 11; c++) step();
    chk("pre_load_shows_zero", {25'd0, seg}, 32'h3F);
    step();
    chk("post_load_new_value", {25'd0, seg}, 32'h4F);
    for (int c = 0; c < 2 * FR; c++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
